// File: rtl/i2s_trnmtr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_trnmtr_ctrl_if
// Brief    : Handshake, strobe and I2S timing signals of the I2S TX controller.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_trnmtr_ctrl_if;
    logic enable;
    logic sample_valid;
    logic sck;
    logic ws;
    logic load;
    logic shift;
    logic wsd;
    logic sample_ack;
    logic underrun;
    logic busy;

    // master is the timing controller; slave is the upstream/shift-register side
    modport master (
        input  enable, sample_valid,
        output sck, ws, load, shift, wsd, sample_ack, underrun, busy
    );

    modport slave (
        output enable, sample_valid,
        input  sck, ws, load, shift, wsd, sample_ack, underrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2s_trnmtr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2s_trnmtr_ctrl
// Brief    : I2S transmit timing controller: sck/ws generation, shift-register
//            strobes and stereo-sample handshake with frame-aligned stop.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_trnmtr_ctrl #(
    parameter int HALF_DIV  = 4,
    parameter int WORD_BITS = 16
) (
    input  wire logic          clk,
    input  wire logic          n_rst,
    i2s_trnmtr_ctrl_if.master  bus
);

    localparam int c_DIV_W = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
    localparam int c_BIT_W = $clog2(WORD_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(HALF_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(WORD_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_START = c_BIT_W'(WORD_BITS - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [c_DIV_W-1:0] r_div_cnt,  w_div_cnt_nxt;
    logic [c_BIT_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic               r_frame_ok, w_frame_ok_nxt;
    logic               r_sck,      w_sck_nxt;
    logic               r_ws,       w_ws_nxt;
    logic               r_wsd,      w_wsd_nxt;
    logic               r_load,     w_load_nxt;
    logic               r_shift,    w_shift_nxt;
    logic               r_ack,      w_ack_nxt;
    logic               r_underrun, w_underrun_nxt;
    logic               r_busy,     w_busy_nxt;

    logic               w_tick;
    logic [c_BIT_W-1:0] w_nb;

    assign w_tick = (r_div_cnt == c_DIV_LAST);
    assign w_nb   = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= c_BIT_START;
            r_frame_ok <= 1'b0;
            r_sck      <= 1'b0;
            r_ws       <= 1'b1;
            r_wsd      <= 1'b0;
            r_load     <= 1'b0;
            r_shift    <= 1'b0;
            r_ack      <= 1'b0;
            r_underrun <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_frame_ok <= w_frame_ok_nxt;
            r_sck      <= w_sck_nxt;
            r_ws       <= w_ws_nxt;
            r_wsd      <= w_wsd_nxt;
            r_load     <= w_load_nxt;
            r_shift    <= w_shift_nxt;
            r_ack      <= w_ack_nxt;
            r_underrun <= w_underrun_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_cnt_nxt  = r_div_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_frame_ok_nxt = r_frame_ok;
        w_sck_nxt      = r_sck;
        w_ws_nxt       = r_ws;
        w_wsd_nxt      = r_wsd;
        w_load_nxt     = 1'b0;
        w_shift_nxt    = 1'b0;
        w_ack_nxt      = 1'b0;
        w_underrun_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sck_nxt     = 1'b0;
                w_ws_nxt      = 1'b1;
                w_bit_cnt_nxt = c_BIT_START;
                w_div_cnt_nxt = '0;
                if (bus.enable) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN, S_DRAIN: begin
                w_div_cnt_nxt = w_tick ? '0 : r_div_cnt + 1'b1;
                if (r_state == S_RUN && !bus.enable) begin
                    w_state_nxt = S_DRAIN;
                end else if (r_state == S_DRAIN && bus.enable) begin
                    w_state_nxt = S_RUN;
                end

                if (w_tick) begin
                    w_sck_nxt = ~r_sck;
                    // sck falling: all strobes coincide with sck going low
                    if (r_sck) begin
                        w_bit_cnt_nxt = w_nb;
                        if (w_nb == c_BIT_LAST) begin
                            w_ws_nxt    = ~r_ws;
                            w_shift_nxt = 1'b1;
                        end else if (w_nb == '0) begin
                            if (r_state == S_DRAIN && !r_ws) begin
                                // stop at the frame boundary instead of starting a new left word
                                w_state_nxt   = S_IDLE;
                                w_sck_nxt     = 1'b0;
                                w_ws_nxt      = 1'b1;
                                w_bit_cnt_nxt = c_BIT_START;
                                w_div_cnt_nxt = '0;
                            end else begin
                                w_load_nxt = 1'b1;
                                w_wsd_nxt  = r_ws;
                                if (!r_ws) begin
                                    w_frame_ok_nxt = bus.sample_valid;
                                    w_underrun_nxt = !bus.sample_valid;
                                end else begin
                                    w_ack_nxt = r_frame_ok;
                                end
                            end
                        end else begin
                            w_shift_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.sck        = r_sck;
    assign bus.ws         = r_ws;
    assign bus.wsd        = r_wsd;
    assign bus.load       = r_load;
    assign bus.shift      = r_shift;
    assign bus.sample_ack = r_ack;
    assign bus.underrun   = r_underrun;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
